// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch sequencer feeding a DEPTH-entry FIFO of
// {pc, instr} pairs toward decode. One fetch is in flight at a time; the
// FSM stops issuing when the queue fills (HOLD) and discards the stale
// response of a request that was in flight when a redirect arrived (DROP).
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let a response go
// straight to decode in the same cycle when the queue is empty.
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         ireq_valid,
  output logic [PC_W-1:0]              ireq_addr,
  input  logic                         iresp_valid,
  input  logic [31:0]                  iresp_data,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         deq_ready,
  output logic                         deq_valid,
  output logic [31:0]                  deq_instr,
  output logic [PC_W-1:0]              deq_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, HOLD, DROP} state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [PC_W-1:0] req_pc, req_pc_nxt;
  logic [CW-1:0]   count_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  entry_t          mem [DEPTH];
  logic            enq, pop, bypass;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue and decode ready: hand the response straight through.
  assign bypass = !reset && (count == '0) && (state == RUN) && iresp_valid
                  && !redirect_valid && deq_ready;
  assign deq_valid = bypass || (count != '0);
  assign deq_instr = bypass ? iresp_data : mem[rd_ptr].instr;
  assign deq_pc    = bypass ? req_pc     : mem[rd_ptr].pc;
`else
  assign bypass    = 1'b0;
  assign deq_valid = (count != '0);
  assign deq_instr = mem[rd_ptr].instr;
  assign deq_pc    = mem[rd_ptr].pc;
`endif

  // Redirect wins: it flushes the queue and cancels any same-cycle pop.
  assign pop = (count != '0) && deq_ready && !redirect_valid;
  assign enq = (state == RUN) && iresp_valid && !redirect_valid && !bypass;

  // Reset must silence the request immediately, before any clock edge.
  assign ireq_valid = !reset && (state != HOLD);
  assign ireq_addr  = req_pc;

  // Next-state, next-PC and occupancy.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_pc_nxt   = req_pc;
    count_nxt    = count + CW'(enq) - CW'(pop);
    if (redirect_valid) count_nxt = '0;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          if (iresp_valid) req_pc_nxt = redirect_pc;  // response dropped
          else             state_nxt  = DROP;         // old fetch still owed
        end else begin
          if (iresp_valid) begin
            fetch_pc_nxt = req_pc + PC_W'(4);
            req_pc_nxt   = req_pc + PC_W'(4);
          end
          if (count_nxt == CW'(DEPTH)) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_pc;
          req_pc_nxt   = redirect_pc;
          state_nxt    = RUN;
        end else if (count_nxt != CW'(DEPTH)) begin
          req_pc_nxt = fetch_pc;
          state_nxt  = RUN;
        end
      end
      DROP: begin
        if (redirect_valid) fetch_pc_nxt = redirect_pc;
        if (iresp_valid) begin
          req_pc_nxt = fetch_pc_nxt;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // PC, occupancy and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      req_pc   <= req_pc_nxt;
      count    <= count_nxt;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= ptr_inc(wr_ptr);
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Queue storage; contents are don't-care until count covers them.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{pc: req_pc, instr: iresp_data};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue at default parameters (DEPTH=4, PC_W=64).
module tb_fetch_queue;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [63:0] deq_pc;
  logic [2:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; iresp_valid = 1'b0; redirect_valid = 1'b0; deq_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_chk++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ireq_valid: got %b exp 0", ireq_valid); end
    n_chk++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL rst_deq_valid: got %b exp 0", deq_valid); end
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", count); end
    reset = 1'b0; #1;
    n_chk++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL first_ireq_valid: got %b exp 1", ireq_valid); end
    n_chk++; if (ireq_addr !== BASE) begin n_fail++; $display("FAIL first_ireq_addr: got %h exp %h", ireq_addr, BASE); end
  endtask

  // Response every cycle with decode always ready.
  task automatic test_stream();
    logic [31:0] d, prev;
    prev = '0;
    deq_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 32'h13 + 32'(i) * 32'h100;
      n_chk++; if (ireq_addr !== BASE + 64'(4*i)) begin n_fail++; $display("FAIL stream_addr%0d: got %h exp %h", i, ireq_addr, BASE + 64'(4*i)); end
      iresp_valid = 1'b1; iresp_data = d; #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      n_chk++; if (deq_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid%0d: got %b exp 1", i, deq_valid); end
      n_chk++; if (deq_instr !== d) begin n_fail++; $display("FAIL byp_instr%0d: got %h exp %h", i, deq_instr, d); end
      n_chk++; if (deq_pc !== BASE + 64'(4*i)) begin n_fail++; $display("FAIL byp_pc%0d: got %h exp %h", i, deq_pc, BASE + 64'(4*i)); end
      n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL byp_count%0d: got %0d exp 0", i, count); end
`else
      if (i == 0) begin
        n_chk++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL no_comb_path: got %b exp 0", deq_valid); end
      end else begin
        n_chk++; if (deq_pc !== BASE + 64'(4*(i-1))) begin n_fail++; $display("FAIL stream_pc%0d: got %h exp %h", i, deq_pc, BASE + 64'(4*(i-1))); end
        n_chk++; if (deq_instr !== prev) begin n_fail++; $display("FAIL stream_instr%0d: got %h exp %h", i, deq_instr, prev); end
        n_chk++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count%0d: got %0d exp 1", i, count); end
      end
`endif
      prev = d;
      tick();
    end
    iresp_valid = 1'b0;
    tick();
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL stream_drain: got %0d exp 0", count); end
    deq_ready = 1'b0;
  endtask

  // Fill to DEPTH with decode stalled, then release one entry.
  task automatic test_hold();
    do_reset();
    iresp_valid = 1'b1; iresp_data = 32'h0000_0093;
    repeat (4) tick();
    iresp_valid = 1'b0;
    n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL hold_count: got %0d exp 4", count); end
    n_chk++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ireq_valid: got %b exp 0", ireq_valid); end
    n_chk++; if (deq_pc !== BASE) begin n_fail++; $display("FAIL hold_head_pc: got %h exp %h", deq_pc, BASE); end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    n_chk++; if (count !== 3'd3) begin n_fail++; $display("FAIL pop_count: got %0d exp 3", count); end
    n_chk++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid: got %b exp 1", ireq_valid); end
    n_chk++; if (ireq_addr !== BASE + 64'h10) begin n_fail++; $display("FAIL resume_addr: got %h exp %h", ireq_addr, BASE + 64'h10); end
    n_chk++; if (deq_pc !== BASE + 64'h4) begin n_fail++; $display("FAIL fifo_order: got %h exp %h", deq_pc, BASE + 64'h4); end
  endtask

  // Redirect with a request outstanding and no response.
  task automatic test_redirect_drop();
    do_reset();
    iresp_valid = 1'b1; iresp_data = 32'h1111_1111;
    tick();
    iresp_valid = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL drop_flush: got %0d exp 0", count); end
    n_chk++; if (ireq_addr !== BASE + 64'h4) begin n_fail++; $display("FAIL drop_hold_addr: got %h exp %h", ireq_addr, BASE + 64'h4); end
    tick();
    n_chk++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL drop_valid: got %b exp 1", ireq_valid); end
    n_chk++; if (ireq_addr !== BASE + 64'h4) begin n_fail++; $display("FAIL drop_hold_addr2: got %h exp %h", ireq_addr, BASE + 64'h4); end
    iresp_valid = 1'b1; iresp_data = 32'hDEAD_BEEF;
    tick();
    iresp_valid = 1'b0;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL drop_discard: got %0d exp 0", count); end
    n_chk++; if (ireq_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL drop_new_addr: got %h exp 80001000", ireq_addr); end
    iresp_valid = 1'b1; iresp_data = 32'h0000_0033;
    tick();
    iresp_valid = 1'b0;
    n_chk++; if (deq_pc !== 64'h8000_1000) begin n_fail++; $display("FAIL drop_first_pc: got %h exp 80001000", deq_pc); end
    n_chk++; if (deq_instr !== 32'h0000_0033) begin n_fail++; $display("FAIL drop_first_instr: got %h exp 00000033", deq_instr); end
    n_chk++; if (ireq_addr !== 64'h8000_1004) begin n_fail++; $display("FAIL drop_next_addr: got %h exp 80001004", ireq_addr); end
  endtask

  // Redirect and response in the same cycle.
  task automatic test_redirect_resp();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    iresp_valid = 1'b1; iresp_data = 32'hBAD0_0000;
    tick();
    redirect_valid = 1'b0; iresp_valid = 1'b0;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL rr_count: got %0d exp 0", count); end
    n_chk++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL rr_deq_valid: got %b exp 0", deq_valid); end
    n_chk++; if (ireq_addr !== 64'h8000_2000) begin n_fail++; $display("FAIL rr_addr: got %h exp 80002000", ireq_addr); end
  endtask

  // Redirect while full; the same-cycle pop must be ignored.
  task automatic test_redirect_hold();
    iresp_valid = 1'b1; iresp_data = 32'h0000_0013;
    repeat (4) tick();
    iresp_valid = 1'b0;
    n_chk++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL rh_full: got %b exp 0", ireq_valid); end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_3000; deq_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; deq_ready = 1'b0;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL rh_count: got %0d exp 0", count); end
    n_chk++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL rh_valid: got %b exp 1", ireq_valid); end
    n_chk++; if (ireq_addr !== 64'h8000_3000) begin n_fail++; $display("FAIL rh_addr: got %h exp 80003000", ireq_addr); end
  endtask

  // Asynchronous reset while full in HOLD.
  task automatic test_async_reset();
    iresp_valid = 1'b1; iresp_data = 32'h0000_0013;
    repeat (4) tick();
    iresp_valid = 1'b0;
    n_chk++; if (count !== 3'd4) begin n_fail++; $display("FAIL ar_pre_count: got %0d exp 4", count); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL ar_count: got %0d exp 0", count); end
    n_chk++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL ar_deq_valid: got %b exp 0", deq_valid); end
    n_chk++; if (ireq_valid !== 1'b0) begin n_fail++; $display("FAIL ar_ireq_valid: got %b exp 0", ireq_valid); end
    tick();
    reset = 1'b0; #1;
    n_chk++; if (ireq_addr !== BASE) begin n_fail++; $display("FAIL ar_restart_addr: got %h exp %h", ireq_addr, BASE); end
    n_chk++; if (ireq_valid !== 1'b1) begin n_fail++; $display("FAIL ar_restart_valid: got %b exp 1", ireq_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_redirect_drop();
    test_redirect_resp();
    test_redirect_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
